// File: rtl/polygon_scene_loader.sv
// Double-buffered polygon table: vertices stream into the back bank and the
// banks swap at the first cycle of vertical blanking, so a frame never tears.
module polygon_scene_loader #(
  parameter int PIXEL_WIDTH            = 1280,
  parameter int PIXEL_HEIGHT           = 720,
  parameter int MAX_NUM_VERTICES       = 8,
  parameter int MAX_POLYGONS_ON_SCREEN = 4,
  localparam int VW  = $clog2(MAX_NUM_VERTICES + 1),
  localparam int PW  = $clog2(MAX_POLYGONS_ON_SCREEN + 1),
  localparam int NV  = MAX_POLYGONS_ON_SCREEN * MAX_NUM_VERTICES,
  localparam int HW  = $clog2(PIXEL_WIDTH),
  localparam int VCW = $clog2(PIXEL_HEIGHT)
) (
  input  logic                                 clk_in,
  input  logic                                 rst_in,
  input  logic [HW-1:0]                        hcount_in,
  input  logic [VCW-1:0]                       vcount_in,
  input  logic                                 vertex_valid_in,
  output logic                                 vertex_ready_out,
  input  logic signed [31:0]                   vertex_x_in,
  input  logic signed [31:0]                   vertex_y_in,
  input  logic                                 poly_last_in,
  input  logic                                 scene_last_in,
  output logic [32*NV-1:0]                     xs_out,
  output logic [32*NV-1:0]                     ys_out,
  output logic [VW*MAX_POLYGONS_ON_SCREEN-1:0] num_sides_out,
  output logic [PW-1:0]                        polygons_on_screen_out,
  output logic                                 swap_out,
  output logic                                 overflow_out
);

  localparam int MV  = MAX_NUM_VERTICES;
  localparam int MP  = MAX_POLYGONS_ON_SCREEN;
  localparam int NIW = (NV > 1) ? $clog2(NV) : 1;
  localparam int PIW = (MP > 1) ? $clog2(MP) : 1;

  localparam logic [0:0] S_FILL = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;

  logic [0:0]         r_state;
  logic               r_front;
  logic [VW-1:0]      r_vcnt;
  logic [PW-1:0]      r_pcnt;
  logic [PW-1:0]      r_scene_cnt;
  logic [PW-1:0]      r_pos;
  logic               r_ready;
  logic               r_swap;
  logic               r_ovf;
  logic               r_at_pt;
  logic signed [31:0] r_xs    [2][NV];
  logic signed [31:0] r_ys    [2][NV];
  logic [VW-1:0]      r_sides [2][MP];

  logic           w_at_pt;
  logic           w_boundary;
  logic           w_accept;
  logic           w_room;
  logic           w_store;
  logic           w_poly_end;
  logic [VW-1:0]  w_n;
  logic           w_keep;
  logic [PW-1:0]  w_pcnt_next;
  logic           w_back;
  logic [NIW-1:0] w_wr_idx;
  logic [PIW-1:0] w_sl_idx;

  // Swap point is edge-detected so a held count still yields a single boundary.
  assign w_at_pt     = (hcount_in == '0) && (vcount_in == VCW'(PIXEL_HEIGHT));
  assign w_boundary  = w_at_pt && !r_at_pt;
  assign w_accept    = vertex_valid_in && r_ready;
  assign w_room      = (r_vcnt < VW'(MV)) && (r_pcnt < PW'(MP));
  assign w_store     = w_accept && w_room;
  assign w_poly_end  = w_accept && (poly_last_in || scene_last_in);
  assign w_n         = r_vcnt + VW'(w_store);
  assign w_keep      = (w_n >= VW'(3));
  assign w_pcnt_next = r_pcnt + PW'(w_keep);
  assign w_back      = ~r_front;
  assign w_wr_idx    = NIW'(r_pcnt) * NIW'(MV) + NIW'(r_vcnt);
  assign w_sl_idx    = r_pcnt[PIW-1:0];

  assign vertex_ready_out       = r_ready;
  assign polygons_on_screen_out = r_pos;
  assign swap_out               = r_swap;
  assign overflow_out           = r_ovf;

  for (genvar g_p = 0; g_p < MP; g_p++) begin : g_slot
    assign num_sides_out[g_p*VW +: VW] = r_sides[r_front][g_p];
    for (genvar g_v = 0; g_v < MV; g_v++) begin : g_vtx
      assign xs_out[(g_p*MV+g_v)*32 +: 32] = r_xs[r_front][g_p*MV+g_v];
      assign ys_out[(g_p*MV+g_v)*32 +: 32] = r_ys[r_front][g_p*MV+g_v];
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      // NOTE: the banks are plain flops and are cleared on reset so the
      // renderer never sees stale coordinates after a reset mid-scene.
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < NV; i++) begin
          r_xs[b][i] <= '0;
          r_ys[b][i] <= '0;
        end
        for (int p = 0; p < MP; p++) r_sides[b][p] <= '0;
      end
      r_state     <= S_FILL;
      r_front     <= 1'b0;
      r_vcnt      <= '0;
      r_pcnt      <= '0;
      r_scene_cnt <= '0;
      r_pos       <= '0;
      r_ready     <= 1'b0;
      r_swap      <= 1'b0;
      r_ovf       <= 1'b0;
      r_at_pt     <= 1'b0;
    end else begin
      r_at_pt <= w_at_pt;
      r_swap  <= 1'b0;

      if (w_store) begin
        r_xs[w_back][w_wr_idx] <= vertex_x_in;
        r_ys[w_back][w_wr_idx] <= vertex_y_in;
        r_vcnt                 <= r_vcnt + 1'b1;
      end
      if (w_accept && !w_room) r_ovf <= 1'b1;

      // Degenerate polygons leave pcnt alone so their slot is reused.
      if (w_poly_end) begin
        r_vcnt <= '0;
        if (w_keep) begin
          r_sides[w_back][w_sl_idx] <= w_n;
          r_pcnt                    <= w_pcnt_next;
        end
      end

      if (w_accept && scene_last_in) begin
        r_state     <= S_WAIT;
        r_ready     <= 1'b0;
        r_scene_cnt <= w_pcnt_next;
      end else if (r_state == S_WAIT && w_boundary) begin
        r_front <= ~r_front;
        r_pos   <= r_scene_cnt;
        r_swap  <= 1'b1;
        r_pcnt  <= '0;
        r_vcnt  <= '0;
        for (int p = 0; p < MP; p++) r_sides[r_front][p] <= '0;
        r_state <= S_FILL;
        r_ready <= 1'b1;
      end else if (r_state == S_FILL) begin
        r_ready <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_polygon_scene_loader.sv
// Scoreboard bench for polygon_scene_loader: expected scenes are queued as
// they are streamed and compared against the front bank on every swap pulse.
module tb_polygon_scene_loader;

  localparam int MV = 8;
  localparam int MP = 4;
  localparam int NV = MV * MP;
  localparam int VW = 4;
  localparam int PW = 3;

  logic              clk_in = 1'b0;
  logic              rst_in;
  logic [10:0]       hcount_in;
  logic [9:0]        vcount_in;
  logic              vertex_valid_in;
  logic              vertex_ready_out;
  logic signed [31:0] vertex_x_in;
  logic signed [31:0] vertex_y_in;
  logic              poly_last_in;
  logic              scene_last_in;
  logic [32*NV-1:0]  xs_out;
  logic [32*NV-1:0]  ys_out;
  logic [VW*MP-1:0]  num_sides_out;
  logic [PW-1:0]     polygons_on_screen_out;
  logic              swap_out;
  logic              overflow_out;

  polygon_scene_loader dut (
    .clk_in                 (clk_in),
    .rst_in                 (rst_in),
    .hcount_in              (hcount_in),
    .vcount_in              (vcount_in),
    .vertex_valid_in        (vertex_valid_in),
    .vertex_ready_out       (vertex_ready_out),
    .vertex_x_in            (vertex_x_in),
    .vertex_y_in            (vertex_y_in),
    .poly_last_in           (poly_last_in),
    .scene_last_in          (scene_last_in),
    .xs_out                 (xs_out),
    .ys_out                 (ys_out),
    .num_sides_out          (num_sides_out),
    .polygons_on_screen_out (polygons_on_screen_out),
    .swap_out               (swap_out),
    .overflow_out           (overflow_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int count;
    int sides [MP];
    int xs    [NV];
    int ys    [NV];
  } scene_t;

  scene_t exp_q [$];
  scene_t mon_e;
  scene_t e;
  int     n_cmp    = 0;
  int     n_bad    = 0;
  int     swap_cnt = 0;

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_bad++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic scene_t blank_scene();
    scene_t s;
    s.count = 0;
    for (int p = 0; p < MP; p++) s.sides[p] = 0;
    for (int i = 0; i < NV; i++) begin
      s.xs[i] = 0;
      s.ys[i] = 0;
    end
    return s;
  endfunction

  // Expected slot contents for a polygon streamed by send_poly.
  task automatic add_slot(inout scene_t s, input int slot, input int n, input int base);
    s.sides[slot] = (n > MV) ? MV : n;
    for (int v = 0; v < s.sides[slot]; v++) begin
      s.xs[slot*MV+v] = base + 10*v;
      s.ys[slot*MV+v] = base + 500 + v;
    end
  endtask

  // Scoreboard: every swap pulse pops one expected scene.
  always @(negedge clk_in) begin
    if (!rst_in && swap_out === 1'b1) begin
      swap_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_swap", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("poly_count", polygons_on_screen_out, mon_e.count);
        for (int p = 0; p < MP; p++) begin
          check($sformatf("sides%0d", p), num_sides_out[p*VW +: VW], mon_e.sides[p]);
          for (int v = 0; v < mon_e.sides[p]; v++) begin
            check($sformatf("x%0d_%0d", p, v), $signed(xs_out[(p*MV+v)*32 +: 32]), mon_e.xs[p*MV+v]);
            check($sformatf("y%0d_%0d", p, v), $signed(ys_out[(p*MV+v)*32 +: 32]), mon_e.ys[p*MV+v]);
          end
        end
      end
    end
  end

  task automatic send_beat(input int x, input int y, input bit pl, input bit sl);
    int k = 0;
    @(negedge clk_in);
    vertex_valid_in = 1'b1;
    vertex_x_in     = x;
    vertex_y_in     = y;
    poly_last_in    = pl;
    scene_last_in   = sl;
    while (!vertex_ready_out && k < 200) begin
      @(negedge clk_in);
      k++;
    end
    if (!vertex_ready_out) check("ready_timeout", 0, 1);
    @(posedge clk_in);
    #1;
    vertex_valid_in = 1'b0;
    poly_last_in    = 1'b0;
    scene_last_in   = 1'b0;
  endtask

  task automatic send_poly(input int n, input int base, input bit sl);
    for (int i = 0; i < n; i++)
      send_beat(base + 10*i, base + 500 + i, i == n-1, sl && (i == n-1));
  endtask

  task automatic send_square();
    send_beat(100, 100, 1'b0, 1'b0);
    send_beat(200, 100, 1'b0, 1'b0);
    send_beat(200, 200, 1'b0, 1'b0);
    send_beat(100, 200, 1'b1, 1'b1);
  endtask

  function automatic scene_t square_scene();
    scene_t s = blank_scene();
    s.count    = 1;
    s.sides[0] = 4;
    s.xs[0] = 100; s.xs[1] = 200; s.xs[2] = 200; s.xs[3] = 100;
    s.ys[0] = 100; s.ys[1] = 100; s.ys[2] = 200; s.ys[3] = 200;
    return s;
  endfunction

  task automatic hit_boundary(input int hold);
    @(negedge clk_in);
    hcount_in = 11'd0;
    vcount_in = 10'd720;
    repeat (hold) @(negedge clk_in);
    hcount_in = 11'd5;
    vcount_in = 10'd5;
    repeat (3) @(negedge clk_in);
  endtask

  task automatic do_reset();
    @(negedge clk_in);
    rst_in = 1'b1;
    repeat (2) @(negedge clk_in);
    rst_in = 1'b0;
    repeat (2) @(negedge clk_in);
  endtask

  initial begin
    rst_in          = 1'b1;
    hcount_in       = 11'd5;
    vcount_in       = 10'd5;
    vertex_valid_in = 1'b0;
    vertex_x_in     = '0;
    vertex_y_in     = '0;
    poly_last_in    = 1'b0;
    scene_last_in   = 1'b0;

    repeat (3) @(negedge clk_in);
    check("rst_ready", vertex_ready_out, 0);
    check("rst_count", polygons_on_screen_out, 0);
    check("rst_overflow", overflow_out, 0);
    check("rst_swap", swap_out, 0);
    check("rst_sides", num_sides_out, 0);
    check("rst_x0", $signed(xs_out[31:0]), 0);
    rst_in = 1'b0;
    @(negedge clk_in);
    check("ready_after_rst", vertex_ready_out, 1);

    // 1: single square, swapped at a held boundary
    exp_q.push_back(square_scene());
    send_square();
    @(negedge clk_in);
    check("t1_count_before_swap", polygons_on_screen_out, 0);
    hit_boundary(3);
    check("t1_swaps", swap_cnt, 1);

    // 2: triangle + pentagon, held off the boundary for a long time
    e = blank_scene();
    e.count = 2;
    add_slot(e, 0, 3, 1000);
    add_slot(e, 1, 5, 2000);
    exp_q.push_back(e);
    send_poly(3, 1000, 1'b0);
    send_poly(5, 2000, 1'b1);
    @(negedge clk_in);
    check("t2_ready_low", vertex_ready_out, 0);
    repeat (2000) @(negedge clk_in);
    check("t2_count_held", polygons_on_screen_out, 1);
    check("t2_x0_held", $signed(xs_out[31:0]), 100);
    check("t2_no_swap_yet", swap_cnt, 1);
    hit_boundary(2);
    check("t2_swaps", swap_cnt, 2);

    // 3: vertex overflow and slot overflow
    do_reset();
    check("t3_ovf_clear", overflow_out, 0);
    e = blank_scene();
    e.count = 4;
    add_slot(e, 0, 10, 3000);
    add_slot(e, 1, 3, 4000);
    add_slot(e, 2, 3, 5000);
    add_slot(e, 3, 3, 6000);
    exp_q.push_back(e);
    send_poly(10, 3000, 1'b0);
    check("t3_ovf_vertex", overflow_out, 1);
    send_poly(3, 4000, 1'b0);
    send_poly(3, 5000, 1'b0);
    send_poly(3, 6000, 1'b0);
    send_poly(3, 7000, 1'b1);
    hit_boundary(2);
    check("t3_swaps", swap_cnt, 3);
    check("t3_ovf_sticky", overflow_out, 1);

    // 4: degenerate polygon is discarded, slot reused
    do_reset();
    e = blank_scene();
    e.count = 1;
    add_slot(e, 0, 3, 8000);
    exp_q.push_back(e);
    send_poly(2, 9000, 1'b0);
    send_poly(3, 8000, 1'b1);
    hit_boundary(2);
    check("t4_swaps", swap_cnt, 4);
    check("t4_ovf", overflow_out, 0);

    // 5: scene_last accepted on the boundary cycle defers the swap a frame
    e = blank_scene();
    e.count = 1;
    add_slot(e, 0, 3, 1500);
    exp_q.push_back(e);
    send_beat(1500, 2000, 1'b0, 1'b0);
    send_beat(1510, 2001, 1'b0, 1'b0);
    @(negedge clk_in);
    check("t5_ready_at_bnd", vertex_ready_out, 1);
    vertex_valid_in = 1'b1;
    vertex_x_in     = 1520;
    vertex_y_in     = 2002;
    poly_last_in    = 1'b1;
    scene_last_in   = 1'b1;
    hcount_in       = 11'd0;
    vcount_in       = 10'd720;
    @(posedge clk_in);
    #1;
    vertex_valid_in = 1'b0;
    poly_last_in    = 1'b0;
    scene_last_in   = 1'b0;
    repeat (3) @(negedge clk_in);
    hcount_in = 11'd5;
    vcount_in = 10'd5;
    repeat (3) @(negedge clk_in);
    check("t5_no_swap", swap_cnt, 4);
    check("t5_ready_low", vertex_ready_out, 0);
    hit_boundary(2);
    check("t5_swaps", swap_cnt, 5);

    // boundary while filling: front bank persists
    hit_boundary(2);
    check("fill_bnd_no_swap", swap_cnt, 5);
    check("fill_bnd_count", polygons_on_screen_out, 1);
    check("fill_bnd_x0", $signed(xs_out[31:0]), 1500);

    // 6: asynchronous reset mid-stream
    send_beat(11, 12, 1'b0, 1'b0);
    send_beat(13, 14, 1'b0, 1'b0);
    send_beat(15, 16, 1'b0, 1'b0);
    @(negedge clk_in);
    #2 rst_in = 1'b1;
    #1;
    check("t6_async_count", polygons_on_screen_out, 0);
    check("t6_async_sides", num_sides_out, 0);
    check("t6_async_x0", $signed(xs_out[31:0]), 0);
    check("t6_async_ready", vertex_ready_out, 0);
    @(negedge clk_in);
    rst_in = 1'b0;
    @(negedge clk_in);
    check("t6_ready_back", vertex_ready_out, 1);
    exp_q.push_back(square_scene());
    send_square();
    hit_boundary(2);
    check("t6_swaps", swap_cnt, 6);

    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
